// File: rtl/rtc_dir_sequencer_pkg.sv
// Shared encodings for the RTC register-file transfer sequencer: FSM states,
// register indices, bus phase codes and the registered control-output bundle.
package rtc_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD_A = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;
  localparam logic [2:0] ST_FIN_A = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    CMD_A = ST_CMD_A,
    ADDR  = ST_ADDR,
    DATA  = ST_DATA,
    NEXT  = ST_NEXT,
    FIN_A = ST_FIN_A,
    DONE  = ST_DONE
  } state_t;

  // Index 10 decodes to the 0xF0 commit/command address.
  localparam int unsigned CMD_IDX = 10;

  localparam logic [3:0] SEG   = 4'd0;
  localparam logic [3:0] MIN   = 4'd1;
  localparam logic [3:0] HOR   = 4'd2;
  localparam logic [3:0] DIA   = 4'd3;
  localparam logic [3:0] MES   = 4'd4;
  localparam logic [3:0] ANO   = 4'd5;
  localparam logic [3:0] SEG_T = 4'd6;
  localparam logic [3:0] MIN_T = 4'd7;
  localparam logic [3:0] HOR_T = 4'd8;

  localparam logic AD_ADDR = 1'b1;
  localparam logic AD_DATA = 1'b0;

  typedef struct packed {
    logic [3:0] idx;
    logic       deco_en;
    logic       bus_req;
    logic       bus_ad;
    logic       bus_wr;
    logic       busy;
    logic       done;
    logic       rd_valid;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{
    idx:      SEG,
    deco_en:  1'b0,
    bus_req:  1'b0,
    bus_ad:   1'b0,
    bus_wr:   1'b1,
    busy:     1'b0,
    done:     1'b0,
    rd_valid: 1'b0
  };

  function automatic logic is_bus_phase(input state_t s);
    return (s == CMD_A) || (s == ADDR) || (s == DATA) || (s == FIN_A);
  endfunction

endpackage

// File: rtl/rtc_dir_sequencer_if.sv
// Phase handshake between the sequencer (master) and the low-level
// address/data bus driver (slave).
interface rtc_dir_sequencer_if;

  logic       bus_req;
  logic       bus_ad;
  logic       bus_wr;
  logic [7:0] bus_wdata;
  logic       bus_ack;
  logic [7:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_ad,
    output bus_wr,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_ad,
    input  bus_wr,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );

endinterface

// File: rtl/rtc_dir_sequencer_phase_timer.sv
// Per-phase ack timeout counter: cleared on phase entry, counts while the
// phase waits, and flags expiry once the count reaches TIMEOUT.
module rtc_phase_timer #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [7:0] r_count;

  assign o_expired = (r_count == TIMEOUT);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + 8'd1;
    end
  end

endmodule

// File: rtl/rtc_dir_sequencer.sv
// Walks the RTC register file: one address phase plus one data phase per
// register, with the 0xF0 command issued last (write) or first (read).
module rtc_dir_sequencer #(
  parameter int unsigned LAST_IDX = 8,
  parameter int unsigned CMD_IDX  = 10,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic                       i_rw,
  input  logic [7:0]                 i_wr_data,
  output logic [3:0]                 o_idx_out,
  output logic                       o_deco_en,
  rtc_dir_sequencer_if.master        bus,
  output logic [7:0]                 o_rd_data,
  output logic                       o_rd_valid,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error
);

  import rtc_pkg::*;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_idx;
  logic [3:0] w_next_idx;
  logic       r_rw;
  logic       w_next_rw;
  ctrl_t      r_ctrl;
  ctrl_t      w_next_ctrl;
  logic [7:0] r_wdata;
  logic [7:0] r_rd_data;
  logic       r_error;
  logic       w_accept;
  logic       w_timeout;
  logic       w_ack;
  logic       w_expired;
  logic       w_timer_clr;

  // An ack only counts while a request is actually on the bus.
  assign w_ack       = bus.bus_ack & r_ctrl.bus_req;
  assign w_timer_clr = (w_next_state != r_state);

  rtc_phase_timer #(
    .TIMEOUT (8'(TIMEOUT))
  ) u_phase_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_timer_clr),
    .i_en      (is_bus_phase(r_state)),
    .o_expired (w_expired)
  );

  // NOTE: every variable written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_rw    = r_rw;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_next_rw    = i_rw;
          w_next_idx   = SEG;
          w_next_state = i_rw ? ADDR : CMD_A;
        end
      end
      CMD_A: begin
        if (w_ack) begin
          w_next_idx   = SEG;
          w_next_state = ADDR;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = DONE;
        end
      end
      ADDR: begin
        if (w_ack) begin
          w_next_state = DATA;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = DONE;
        end
      end
      DATA: begin
        if (w_ack) begin
          w_next_state = NEXT;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = DONE;
        end
      end
      NEXT: begin
        if (r_idx < 4'(LAST_IDX)) begin
          w_next_idx   = r_idx + 4'd1;
          w_next_state = ADDR;
        end else begin
          w_next_state = r_rw ? FIN_A : DONE;
        end
      end
      FIN_A: begin
        if (w_ack) begin
          w_next_state = DONE;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so the bus
  // driver and decoder see glitch-free levels aligned with the state.
  always_comb begin
    w_next_ctrl     = CTRL_RESET;
    w_next_ctrl.idx = w_next_idx;
    case (w_next_state)
      CMD_A, FIN_A: begin
        w_next_ctrl.idx     = 4'(CMD_IDX);
        w_next_ctrl.deco_en = 1'b1;
        w_next_ctrl.bus_req = 1'b1;
        w_next_ctrl.bus_ad  = AD_ADDR;
        w_next_ctrl.busy    = 1'b1;
      end
      ADDR: begin
        w_next_ctrl.deco_en = 1'b1;
        w_next_ctrl.bus_req = 1'b1;
        w_next_ctrl.bus_ad  = AD_ADDR;
        w_next_ctrl.busy    = 1'b1;
      end
      DATA: begin
        w_next_ctrl.deco_en = 1'b1;
        w_next_ctrl.bus_req = 1'b1;
        w_next_ctrl.bus_ad  = AD_DATA;
        w_next_ctrl.bus_wr  = w_next_rw;
        w_next_ctrl.busy    = 1'b1;
      end
      NEXT: begin
        w_next_ctrl.busy     = 1'b1;
        w_next_ctrl.rd_valid = ~w_next_rw;
      end
      DONE: begin
        w_next_ctrl.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= SEG;
      r_rw      <= 1'b0;
      r_ctrl    <= CTRL_RESET;
      r_wdata   <= 8'd0;
      r_rd_data <= 8'd0;
      r_error   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      r_rw    <= w_next_rw;
      r_ctrl  <= w_next_ctrl;
      if (w_accept) begin
        r_error <= 1'b0;
      end else if (w_timeout) begin
        r_error <= 1'b1;
      end
      if ((r_state == ADDR) && w_ack) begin
        r_wdata <= i_wr_data;
      end
      if ((r_state == DATA) && w_ack && !r_rw) begin
        r_rd_data <= bus.bus_rdata;
      end
    end
  end

  assign o_idx_out     = r_ctrl.idx;
  assign o_deco_en     = r_ctrl.deco_en;
  assign o_busy        = r_ctrl.busy;
  assign o_done        = r_ctrl.done;
  assign o_rd_valid    = r_ctrl.rd_valid;
  assign o_rd_data     = r_rd_data;
  assign o_error       = r_error;
  assign bus.bus_req   = r_ctrl.bus_req;
  assign bus.bus_ad    = r_ctrl.bus_ad;
  assign bus.bus_wr    = r_ctrl.bus_wr;
  assign bus.bus_wdata = r_wdata;

endmodule

// File: tb/tb_rtc_dir_sequencer.sv
// Directed bench for rtc_dir_sequencer: a bus-driver model acks phases and a
// scoreboard of expected phases and read bytes is checked as the DUT acts.
module tb_rtc_dir_sequencer;

  localparam int LAST = 8;
  localparam int CMD  = 10;
  localparam int TMO  = 255;
  // Cycles from the start cycle to the done cycle, both counted.
  localparam int LAT  = 1 + (LAST + 1) * 3 + 1 + 1;

  logic       clk;
  logic       rst;
  logic       start;
  logic       rw;
  logic [7:0] wr_data;
  logic [3:0] idx_out;
  logic       deco_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic       error;

  logic       resp_ack;
  logic       force_ack;
  logic [7:0] resp_rdata;

  rtc_dir_sequencer_if sif();
  assign sif.bus_ack   = resp_ack | force_ack;
  assign sif.bus_rdata = resp_rdata;

  rtc_dir_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .i_rw       (rw),
    .i_wr_data  (wr_data),
    .o_idx_out  (idx_out),
    .o_deco_en  (deco_en),
    .bus        (sif),
    .o_rd_data  (rd_data),
    .o_rd_valid (rd_valid),
    .o_busy     (busy),
    .o_done     (done),
    .o_error    (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic       ad;
    logic [3:0] idx;
    logic       wr;
    logic       chk_wd;
    logic [7:0] wd;
  } phase_t;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] data;
  } rd_t;

  phase_t ph_q[$];
  rd_t    rd_q[$];

  int ack_delay = 0;
  int block_idx = -1;
  int done_cnt  = 0;

  // Bus-driver model and monitor; acks a phase ack_delay cycles into it.
  initial begin : bus_model
    int     wait_n;
    logic   prev_req, prev_ack, prev_ad, prev_data_ack;
    logic [3:0] prev_idx;
    phase_t e;
    rd_t    r;
    wait_n = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_ad = 1'b0;
    prev_data_ack = 1'b0; prev_idx = 4'd0;
    resp_ack = 1'b0; resp_rdata = 8'h00; wr_data = 8'h00;
    forever begin
      @(negedge clk);
      resp_ack   = 1'b0;
      wr_data    = 8'h10 + {4'h0, idx_out};
      resp_rdata = 8'hA0 + {4'h0, idx_out};
      if (done) done_cnt++;
      if (prev_data_ack) check("req_low_in_next", 32'(sif.bus_req), 32'd0);
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
        end else begin
          r = rd_q.pop_front();
          check("rd_idx", 32'(idx_out), 32'(r.idx));
          check("rd_data", 32'(rd_data), 32'(r.data));
        end
      end
      if (sif.bus_req) begin
        if (!prev_req || prev_ack || (sif.bus_ad != prev_ad) || (idx_out != prev_idx))
          wait_n = 0;
        else
          wait_n++;
        if ((wait_n == ack_delay) && !(sif.bus_ad && (int'(idx_out) == block_idx)))
          resp_ack = 1'b1;
      end
      if (resp_ack) begin
        if (ph_q.size() == 0) begin
          check("phase_unexpected", 32'(sif.bus_req), 32'd0);
        end else begin
          e = ph_q.pop_front();
          check("phase_ad", 32'(sif.bus_ad), 32'(e.ad));
          check("phase_idx", 32'(idx_out), 32'(e.idx));
          check("phase_wr", 32'(sif.bus_wr), 32'(e.wr));
          check("phase_deco_en", 32'(deco_en), 32'd1);
          if (e.chk_wd) check("phase_wdata", 32'(sif.bus_wdata), 32'(e.wd));
        end
      end
      prev_data_ack = resp_ack && !sif.bus_ad;
      prev_req = sif.bus_req;
      prev_ack = resp_ack;
      prev_ad  = sif.bus_ad;
      prev_idx = idx_out;
    end
  end

  task automatic push_write();
    for (int i = 0; i <= LAST; i++) begin
      ph_q.push_back('{ad: 1'b1, idx: 4'(i), wr: 1'b1, chk_wd: 1'b0, wd: 8'h00});
      ph_q.push_back('{ad: 1'b0, idx: 4'(i), wr: 1'b1, chk_wd: 1'b1, wd: 8'(8'h10 + i)});
    end
    ph_q.push_back('{ad: 1'b1, idx: 4'(CMD), wr: 1'b1, chk_wd: 1'b0, wd: 8'h00});
  endtask

  task automatic push_read();
    ph_q.push_back('{ad: 1'b1, idx: 4'(CMD), wr: 1'b1, chk_wd: 1'b0, wd: 8'h00});
    for (int i = 0; i <= LAST; i++) begin
      ph_q.push_back('{ad: 1'b1, idx: 4'(i), wr: 1'b1, chk_wd: 1'b0, wd: 8'h00});
      ph_q.push_back('{ad: 1'b0, idx: 4'(i), wr: 1'b0, chk_wd: 1'b0, wd: 8'h00});
      rd_q.push_back('{idx: 4'(i), data: 8'(8'hA0 + i)});
    end
  endtask

  task automatic pulse_start(input logic mode);
    @(negedge clk);
    rw    = mode;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge of the first cycle after start; n counts from 1.
  task automatic wait_done(input string tag, output int n);
    n = 1;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!done) check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idx"}, 32'(idx_out), 32'd0);
    check({tag, "_deco_en"}, 32'(deco_en), 32'd0);
    check({tag, "_req"}, 32'(sif.bus_req), 32'd0);
    check({tag, "_ad"}, 32'(sif.bus_ad), 32'd0);
    check({tag, "_wr"}, 32'(sif.bus_wr), 32'd1);
    check({tag, "_wdata"}, 32'(sif.bus_wdata), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    int d0;
    rst = 1'b1; start = 1'b0; rw = 1'b0; force_ack = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Write, ack two cycles into every phase
    ack_delay = 2;
    push_write();
    pulse_start(1'b1);
    check("wr_busy_after_start", 32'(busy), 32'd1);
    wait_done("wr_done_timeout", n);
    check("wr_error", 32'(error), 32'd0);
    check("wr_busy_at_done", 32'(busy), 32'd0);
    check("wr_phases_left", 32'(ph_q.size()), 32'd0);
    @(negedge clk);
    check("wr_done_single_cycle", 32'(done), 32'd0);

    // Read, immediate ack
    ack_delay = 0;
    push_read();
    pulse_start(1'b0);
    wait_done("rd_done_timeout", n);
    check("rd_latency", 32'(n + 1), 32'(LAT));
    check("rd_phases_left", 32'(ph_q.size()), 32'd0);
    check("rd_bytes_left", 32'(rd_q.size()), 32'd0);
    check("rd_error", 32'(error), 32'd0);

    // Write, immediate ack: exact latency
    push_write();
    pulse_start(1'b1);
    wait_done("wr0_done_timeout", n);
    check("wr0_latency", 32'(n + 1), 32'(LAT));
    check("wr0_phases_left", 32'(ph_q.size()), 32'd0);

    // No ack on the ADDR phase of idx 3
    block_idx = 3;
    for (int i = 0; i < 3; i++) begin
      ph_q.push_back('{ad: 1'b1, idx: 4'(i), wr: 1'b1, chk_wd: 1'b0, wd: 8'h00});
      ph_q.push_back('{ad: 1'b0, idx: 4'(i), wr: 1'b1, chk_wd: 1'b1, wd: 8'(8'h10 + i)});
    end
    pulse_start(1'b1);
    n = 0;
    while (!(sif.bus_req && sif.bus_ad && idx_out == 4'd3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to_reached_idx3", 32'(idx_out), 32'd3);
    n = 0;
    while (sif.bus_req && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("to_req_cycles", 32'(n), 32'(TMO + 1));
    check("to_done", 32'(done), 32'd1);
    check("to_error", 32'(error), 32'd1);
    check("to_req_low", 32'(sif.bus_req), 32'd0);
    check("to_busy", 32'(busy), 32'd0);
    check("to_phases_left", 32'(ph_q.size()), 32'd0);
    block_idx = -1;
    @(negedge clk);
    check("to_error_sticky", 32'(error), 32'd1);
    push_read();
    pulse_start(1'b0);
    check("to_error_cleared", 32'(error), 32'd0);
    wait_done("to_rd_done_timeout", n);
    check("to_rd_phases_left", 32'(ph_q.size()), 32'd0);
    check("to_rd_error", 32'(error), 32'd0);

    // bus_ack in IDLE is ignored
    @(negedge clk);
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ack_busy", 32'(busy), 32'd0);
    check("idle_ack_req", 32'(sif.bus_req), 32'd0);
    check("idle_ack_done", 32'(done), 32'd0);
    check("idle_ack_deco_en", 32'(deco_en), 32'd0);
    check("idle_ack_rd_valid", 32'(rd_valid), 32'd0);

    // start with bus_ack in IDLE, then start again while busy
    ack_delay = 1;
    d0 = done_cnt;
    push_write();
    rw = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    force_ack = 1'b0;
    repeat (10) @(negedge clk);
    rw = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("rs_done_timeout", n);
    repeat (40) @(negedge clk);
    check("rs_done_count", 32'(done_cnt - d0), 32'd1);
    check("rs_phases_left", 32'(ph_q.size()), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);

    // Reset in the DATA phase of idx 5
    ack_delay = 2;
    push_write();
    pulse_start(1'b1);
    n = 0;
    while (!(sif.bus_req && !sif.bus_ad && idx_out == 4'd5) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_data5", 32'(idx_out), 32'd5);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    ph_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_no_commit_req", 32'(sif.bus_req), 32'd0);
    check("rst_no_commit_busy", 32'(busy), 32'd0);
    ack_delay = 0;
    push_read();
    pulse_start(1'b0);
    check("rst_restart_idx", 32'(idx_out), 32'(CMD));
    wait_done("rst_rd_done_timeout", n);
    check("rst_rd_latency", 32'(n + 1), 32'(LAT));
    check("rst_rd_phases_left", 32'(ph_q.size()), 32'd0);
    check("rst_rd_bytes_left", 32'(rd_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
